issue_alloc: RTL and testbench

Parametrised issue-stage allocator for the Tomasulo core. Each cycle it accepts at most one decoded instruction and assigns it a reorder-buffer slot from a circular ROB pointer. It also assigns a reservation-station entry from the matching functional-unit class, or raises a structural hazard. It owns ROB head/tail/occupancy and per-entry RS busy bits, and it handles commit, RS release and pipeline flush.

---
 rtl/tomasulo_pkg.sv | 22 ++
 rtl/issue_alloc_free_pick.sv | 23 ++
 rtl/issue_alloc.sv | 117 +++++++++++
 tb/tb_issue_alloc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared opcode encodings and functional-unit class mapping for the Tomasulo issue stage.
package tomasulo_pkg;

  localparam int unsigned OP_LOAD  = 0;
  localparam int unsigned OP_STORE = 1;
  localparam int unsigned OP_ADD   = 2;
  localparam int unsigned OP_SUB   = 3;
  localparam int unsigned OP_MUL   = 4;
  localparam int unsigned OP_DIV   = 5;

  typedef enum logic [1:0] {CLS_LS, CLS_ADD, CLS_MUL, CLS_BAD} cls_e;

  function automatic cls_e op_class(input int unsigned op);
    case (op)
      OP_LOAD, OP_STORE: return CLS_LS;
      OP_ADD,  OP_SUB:   return CLS_ADD;
      OP_MUL,  OP_DIV:   return CLS_MUL;
      default:           return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/issue_alloc_free_pick.sv
// Lowest-zero finder over one RS class busy slice.
module free_pick #(
  parameter int W    = 4,
  parameter int OFFW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]    i_busy,
  output logic            o_found,
  output logic [OFFW-1:0] o_off
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    o_found = 1'b0;
    o_off   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!i_busy[i]) begin
        o_found = 1'b1;
        o_off   = OFFW'(i);
      end
    end
  end

endmodule

// File: rtl/issue_alloc.sv
// Issue-stage allocator: grants a ROB slot and a class-matched RS entry per cycle,
// and tracks ROB head/tail/occupancy plus RS busy bits across commit, release and flush.
module issue_alloc
  import tomasulo_pkg::*;
#(
  parameter int ROB_DEPTH = 8,
  parameter int N_LS      = 6,
  parameter int N_ADD     = 3,
  parameter int N_MUL     = 2,
  parameter int OP_W      = 3,
  localparam int ROB_W    = $clog2(ROB_DEPTH),
  localparam int N_RS     = N_LS + N_ADD + N_MUL,
  localparam int RS_W     = $clog2(N_RS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  output logic              issue_ready,
  output logic [ROB_W-1:0]  rob_idx,
  output logic [RS_W-1:0]   rs_idx,
  output logic              struct_haz,
  output logic              illegal_op,
  input  logic              commit_valid,
  input  logic              rs_release_valid,
  input  logic [RS_W-1:0]   rs_release_idx,
  input  logic              flush,
  output logic [ROB_W-1:0]  rob_head,
  output logic [ROB_W:0]    rob_count,
  output logic [N_RS-1:0]   rs_busy
);

  localparam int LS_OW  = (N_LS  > 1) ? $clog2(N_LS)  : 1;
  localparam int ADD_OW = (N_ADD > 1) ? $clog2(N_ADD) : 1;
  localparam int MUL_OW = (N_MUL > 1) ? $clog2(N_MUL) : 1;
  localparam logic [RS_W-1:0] RS_NONE = RS_W'(N_RS);

  logic [ROB_W-1:0] r_head, r_tail;
  logic [ROB_W:0]   r_count;
  logic [N_RS-1:0]  r_busy;

  logic              w_ls_found, w_add_found, w_mul_found;
  logic [LS_OW-1:0]  w_ls_off;
  logic [ADD_OW-1:0] w_add_off;
  logic [MUL_OW-1:0] w_mul_off;
  cls_e              w_cls;
  logic              w_legal, w_found, w_rob_full, w_fire, w_commit;
  logic [RS_W-1:0]   w_pick;
  logic [N_RS-1:0]   w_busy_nxt;

  free_pick #(.W(N_LS)) u_pick_ls (
    .i_busy(r_busy[N_LS-1:0]), .o_found(w_ls_found), .o_off(w_ls_off));
  free_pick #(.W(N_ADD)) u_pick_add (
    .i_busy(r_busy[N_LS+N_ADD-1:N_LS]), .o_found(w_add_found), .o_off(w_add_off));
  free_pick #(.W(N_MUL)) u_pick_mul (
    .i_busy(r_busy[N_RS-1:N_LS+N_ADD]), .o_found(w_mul_found), .o_off(w_mul_off));

  always_comb begin
    w_cls   = op_class(32'(issue_op));
    w_legal = (w_cls != CLS_BAD);
    w_found = 1'b0;
    w_pick  = RS_NONE;
    case (w_cls)
      CLS_LS: begin
        w_found = w_ls_found;
        w_pick  = RS_W'(w_ls_off);
      end
      CLS_ADD: begin
        w_found = w_add_found;
        w_pick  = RS_W'(N_LS) + RS_W'(w_add_off);
      end
      CLS_MUL: begin
        w_found = w_mul_found;
        w_pick  = RS_W'(N_LS + N_ADD) + RS_W'(w_mul_off);
      end
      default: ;
    endcase
  end

  // Full is judged on start-of-cycle occupancy; a same-cycle commit never unblocks issue.
  assign w_rob_full  = (r_count == (ROB_W+1)'(ROB_DEPTH));
  assign issue_ready = !flush && !w_rob_full && w_legal && w_found;
  assign rs_idx      = issue_ready ? w_pick : RS_NONE;
  assign rob_idx     = r_tail;
  assign struct_haz  = issue_valid && !issue_ready && w_legal;
  assign illegal_op  = issue_valid && !w_legal;
  assign w_fire      = issue_valid && issue_ready;
  assign w_commit    = commit_valid && (r_count != '0);

  // Release clears first, grant sets after, so a grant to the same entry wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < N_RS; i++) begin
      if (rs_release_valid && rs_release_idx == RS_W'(i)) w_busy_nxt[i] = 1'b0;
      if (w_fire && w_pick == RS_W'(i))                   w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      if (w_fire)   r_tail <= r_tail + ROB_W'(1);
      if (w_commit) r_head <= r_head + ROB_W'(1);
      r_count <= r_count + (ROB_W+1)'(w_fire) - (ROB_W+1)'(w_commit);
      r_busy  <= w_busy_nxt;
    end
  end

  assign rob_head  = r_head;
  assign rob_count = r_count;
  assign rs_busy   = r_busy;

endmodule

// File: tb/tb_issue_alloc.sv
// Directed scoreboard bench for issue_alloc: expectations are queued as stimulus is
// applied and popped against DUT outputs when they are sampled.
module tb_issue_alloc;

  localparam int ROB_W = 3;
  localparam int RS_W  = 4;
  localparam int N_RS  = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic [2:0]       issue_op;
  logic             issue_ready;
  logic [ROB_W-1:0] rob_idx;
  logic [RS_W-1:0]  rs_idx;
  logic             struct_haz;
  logic             illegal_op;
  logic             commit_valid;
  logic             rs_release_valid;
  logic [RS_W-1:0]  rs_release_idx;
  logic             flush;
  logic [ROB_W-1:0] rob_head;
  logic [ROB_W:0]   rob_count;
  logic [N_RS-1:0]  rs_busy;

  issue_alloc dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_ready(issue_ready), .rob_idx(rob_idx), .rs_idx(rs_idx),
    .struct_haz(struct_haz), .illegal_op(illegal_op), .commit_valid(commit_valid),
    .rs_release_valid(rs_release_valid), .rs_release_idx(rs_release_idx),
    .flush(flush), .rob_head(rob_head), .rob_count(rob_count), .rs_busy(rs_busy));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] act);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0d expected=<none>", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, act, e.val);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic cm,
                       input logic rv, input logic [RS_W-1:0] ri, input logic fl);
    issue_valid = v; issue_op = op; commit_valid = cm;
    rs_release_valid = rv; rs_release_idx = ri; flush = fl;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input int head, input int cnt, input int busy);
    expect_v({tag, "_head"}, head);  check(32'(rob_head));
    expect_v({tag, "_count"}, cnt);  check(32'(rob_count));
    expect_v({tag, "_busy"}, busy);  check(32'(rs_busy));
  endtask

  task automatic chk_grant(input string tag, input int rdy, input int rob, input int rs);
    expect_v({tag, "_ready"}, rdy);  check(32'(issue_ready));
    expect_v({tag, "_rob"}, rob);    check(32'(rob_idx));
    expect_v({tag, "_rs"}, rs);      check(32'(rs_idx));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    chk_reg("rst", 0, 0, 0);

    // ADD class fills at three entries, fourth hazards
    drive(1, 3'd2, 0, 0, 0, 0); chk_grant("add0", 1, 0, 6);  cyc();
    drive(1, 3'd2, 0, 0, 0, 0); chk_grant("add1", 1, 1, 7);  cyc();
    drive(1, 3'd3, 0, 0, 0, 0); chk_grant("sub2", 1, 2, 8);  cyc();
    drive(1, 3'd2, 0, 0, 0, 0); chk_grant("add3", 0, 3, 11);
    expect_v("add3_haz", 1); check(32'(struct_haz));
    cyc();
    chk_reg("addfull", 0, 3, 32'h1C0);

    // MUL class: two grants, DIV hazards, released entry usable only next cycle
    drive(1, 3'd4, 0, 0, 0, 0); chk_grant("mul0", 1, 3, 9);  cyc();
    drive(1, 3'd4, 0, 0, 0, 0); chk_grant("mul1", 1, 4, 10); cyc();
    drive(1, 3'd5, 0, 1, 4'd9, 0); chk_grant("div_rel", 0, 5, 11);
    expect_v("div_rel_haz", 1); check(32'(struct_haz));
    cyc();
    drive(1, 3'd5, 0, 0, 0, 0); chk_grant("div_next", 1, 5, 9); cyc();
    chk_reg("muldiv", 0, 6, 32'h7C0);

    // Flush overrides issue and commit
    drive(1, 3'd0, 1, 0, 0, 1); chk_grant("flush", 0, 6, 11);
    expect_v("flush_haz", 1); check(32'(struct_haz));
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk_reg("postflush", 0, 0, 0);
    expect_v("postflush_rob", 0); check(32'(rob_idx));

    // Eight LS issues, releasing the previous entry so the class alternates 0/1
    for (int k = 0; k < 8; k++) begin
      drive(1, (k % 2) ? 3'd1 : 3'd0, 0, k > 0, RS_W'((k + 1) % 2), 0);
      chk_grant($sformatf("ls%0d", k), 1, k, k % 2);
      cyc();
    end
    chk_reg("robfull", 0, 8, 2);

    // Full ROB: same-cycle commit does not unblock issue
    drive(1, 3'd0, 1, 1, 4'd1, 0); chk_grant("full_cm", 0, 0, 11);
    expect_v("full_cm_haz", 1); check(32'(struct_haz));
    cyc();
    chk_reg("after_full", 1, 7, 0);

    // Commit + issue together: count unchanged, tail wrapped to 0
    drive(1, 3'd0, 1, 0, 0, 0); chk_grant("cm_iss", 1, 0, 0); cyc();
    chk_reg("cm_iss", 2, 7, 1);

    drive(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc();
    chk_reg("drained", 1, 0, 1);

    // Commit on empty ROB is ignored
    cyc();
    chk_reg("empty_cm", 1, 0, 1);

    // Illegal opcode: no hazard, no state change; stray releases ignored
    drive(1, 3'd7, 0, 1, 4'd15, 0);
    expect_v("ill_flag", 1); check(32'(illegal_op));
    expect_v("ill_haz", 0);  check(32'(struct_haz));
    chk_grant("ill", 0, 1, 11);
    cyc();
    drive(0, 0, 0, 1, 4'd3, 0); cyc();
    chk_reg("ill_after", 1, 0, 1);

    // Reset mid-stream
    drive(1, 3'd2, 0, 0, 0, 0); chk_grant("pre_rst", 1, 1, 6); cyc();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0);
    chk_reg("midrst", 0, 0, 0);

    // First issue after reset; release of the same idle entry loses to the grant
    drive(1, 3'd0, 0, 1, 4'd0, 0); chk_grant("first", 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk_reg("fire_wins", 0, 1, 1);

    if (sb.size() != 0) begin
      total++; bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
